// File: rtl/fetch_pkg.sv
// Shared constants and queue-entry type for the instruction fetch queue unit.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam int unsigned DEF_PC_INC   = 4;

  // Queue entry at default widths: PC in the upper field, instruction word below.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with simultaneous push/pop and a synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC sequencing, one-deep request tracking and a
// decoupling queue toward decode, with redirect-driven flush.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W   = DEF_ADDR_W,
  parameter int unsigned      DATA_W   = DEF_DATA_W,
  parameter int unsigned      DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned      PC_INC   = DEF_PC_INC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_W-1:0]      instruction,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CntW:0]     pending;
  logic              push, pop;
  logic [EntryW-1:0] head;

  // Queue plus outstanding request must never exceed DEPTH.
  assign pending   = {1'b0, occupancy} + {{CntW{1'b0}}, inflight_q};
  assign imem_req  = rst_n && !redirect && (pending < (CntW + 1)'(DEPTH));
  assign imem_addr = pc_q;

  // A response landing during a redirect cycle is stale; in-flight is also
  // cleared by the redirect so the following cycle's response is dropped too.
  assign push        = inflight_q && !redirect;
  assign instr_valid = (occupancy != '0);
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~ADDR_W'(PC_INC - 1);
    end else if (imem_req) begin
      pc_d          = pc_q + ADDR_W'(PC_INC);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({inflight_pc_q, imem_data}),
    .rdata (head),
    .count (occupancy)
  );

  assign instr_pc    = head[EntryW-1:DATA_W];
  assign instruction = head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a one-cycle-latency memory model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory returns a tagged word one cycle after the address is presented.
  always @(posedge clk) imem_data <= {16'hA5A5, imem_addr[15:0]};

  fetch_queue_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .occupancy   (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    #12;
    chk("rst_occ",   64'(occupancy),   64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_req",   64'(imem_req),    64'd0);
    chk("rst_addr",  64'(imem_addr),   64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_pc",    64'(instr_pc),    64'd0);

    // Streaming after reset release
    step();
    rst_n = 1'b1;
    #1;
    chk("first_req",  64'(imem_req),  64'd1);
    chk("first_addr", 64'(imem_addr), 64'h0);
    step();
    chk("c1_valid", 64'(instr_valid), 64'd0);
    chk("c1_addr",  64'(imem_addr),   64'h4);
    step();
    chk("c2_valid", 64'(instr_valid), 64'd1);
    chk("c2_pc",    64'(instr_pc),    64'h0);
    chk("c2_instr", 64'(instruction), 64'hA5A50000);
    step();
    chk("c3_pc",  64'(instr_pc),  64'h4);
    chk("c3_occ", 64'(occupancy), 64'd1);
    step();
    chk("c4_pc",    64'(instr_pc),    64'h8);
    chk("c4_instr", 64'(instruction), 64'hA5A50008);

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(instr_valid), 64'd0);
    chk("async_occ",   64'(occupancy),   64'd0);
    chk("async_req",   64'(imem_req),    64'd0);
    step();
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    #1;
    chk("rerst_addr", 64'(imem_addr), 64'h0);
    chk("rerst_req",  64'(imem_req),  64'd1);

    // Stall: queue fills to DEPTH, head held
    for (int i = 0; i < 10; i++) step();
    chk("stall_occ",   64'(occupancy),   64'd4);
    chk("stall_req",   64'(imem_req),    64'd0);
    chk("stall_valid", 64'(instr_valid), 64'd1);
    chk("stall_head",  64'(instr_pc),    64'h0);
    instr_ready = 1'b1;
    #1;
    chk("rel0_pc",  64'(instr_pc),  64'h0);
    chk("rel0_occ", 64'(occupancy), 64'd4);
    step();
    chk("rel1_pc",  64'(instr_pc),  64'h4);
    chk("rel1_occ", 64'(occupancy), 64'd3);
    step();
    chk("rel2_pc",  64'(instr_pc),  64'h8);
    chk("rel2_occ", 64'(occupancy), 64'd2);
    step();
    chk("rel3_pc", 64'(instr_pc), 64'hC);
    step();
    chk("rel4_pc",  64'(instr_pc),  64'h10);
    chk("rel4_occ", 64'(occupancy), 64'd2);

    // Redirect to an unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h0000AB12;
    #1;
    chk("rd_req", 64'(imem_req), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("rd_occ",   64'(occupancy),   64'd0);
    chk("rd_valid", 64'(instr_valid), 64'd0);
    chk("rd_req1",  64'(imem_req),    64'd1);
    chk("rd_addr",  64'(imem_addr),   64'h0000AB10);
    step();
    chk("rd_stale", 64'(instr_valid), 64'd0);
    step();
    chk("rd_pc0",    64'(instr_pc),    64'h0000AB10);
    chk("rd_instr0", 64'(instruction), 64'hA5A5AB10);
    step();
    chk("rd_pc1", 64'(instr_pc), 64'h0000AB14);

    // Redirect coincident with a pop while full
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("full_occ", 64'(occupancy), 64'd4);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h00000100;
    #1;
    chk("fr_req",   64'(imem_req),    64'd0);
    chk("fr_valid", 64'(instr_valid), 64'd1);
    step();
    redirect = 1'b0;
    #1;
    chk("fr_occ",  64'(occupancy),   64'd0);
    chk("fr_addr", 64'(imem_addr),   64'h100);
    step();
    chk("fr_empty", 64'(instr_valid), 64'd0);
    step();
    chk("fr_pc0", 64'(instr_pc), 64'h100);
    step();
    chk("fr_pc1", 64'(instr_pc), 64'h104);
    step();
    chk("fr_pc2", 64'(instr_pc), 64'h108);

    // Back-to-back redirects, last one wins, then PC wraps
    redirect    = 1'b1;
    redirect_pc = 32'h00000500;
    #1;
    chk("bb_req0", 64'(imem_req), 64'd0);
    step();
    redirect_pc = 32'hFFFFFFF9;
    #1;
    chk("bb_req1", 64'(imem_req), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("bb_addr", 64'(imem_addr), 64'hFFFFFFF8);
    chk("bb_occ",  64'(occupancy), 64'd0);
    step();
    chk("wrap_addr", 64'(imem_addr), 64'hFFFFFFFC);
    step();
    chk("wrap_pc0",    64'(instr_pc),    64'hFFFFFFF8);
    chk("wrap_instr0", 64'(instruction), 64'hA5A5FFF8);
    step();
    chk("wrap_pc1", 64'(instr_pc), 64'hFFFFFFFC);
    step();
    chk("wrap_pc2",    64'(instr_pc),    64'h0);
    chk("wrap_instr2", 64'(instruction), 64'hA5A50000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
